cache_request_sequencer: RTL and testbench

Upstream neighbour of the L1 cache. Accepts read/write requests from a CPU-side producer into a small FIFO and drives them one at a time onto the L1 up-port (addr/data/enable/write). Holds enable until the L1 reports completion, then drops enable for a gap so the cache resets its delay counter. Returns read data, latency and timeout status per request.

---
 rtl/cache_request_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_cache_request_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cache_request_sequencer
// Description : Queues CPU-side read/write requests in a small FIFO and plays
//               them one at a time onto the L1 up-port. Holds enable until the
//               L1 signals completion or the request times out, then drops
//               enable for a gap so the cache can reset its delay counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_request_sequencer #(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 63,
  parameter int GAP         = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           reqValid,
  output logic                           reqReady,
  input  logic [ADDR_LENGTH-1:0]         reqAddr,
  input  logic                           reqWrite,
  input  logic [DATA_WIDTH-1:0]          reqData,
  output logic                           respValid,
  output logic [DATA_WIDTH-1:0]          respData,
  output logic                           respWrite,
  output logic [$clog2(TIMEOUT+1)-1:0]   respLatency,
  output logic                           respTimeout,
  output logic [ADDR_LENGTH-1:0]         addrOut,
  output logic [DATA_WIDTH-1:0]          dataOut,
  output logic                           enableOut,
  output logic                           writeOut,
  input  logic [DATA_WIDTH-1:0]          dataIn,
  input  logic                           fetchComplete,
  input  logic                           writeComplete,
  output logic                           busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int EW = ADDR_LENGTH + DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // FIFO entry layout: {write, addr, data}
  logic [EW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  state_t                 state_q, state_d;
  logic [LW-1:0]          lat_q, lat_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [ADDR_LENGTH-1:0] addr_out_q, addr_out_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   enable_out_q, enable_out_d;
  logic                   write_out_q, write_out_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic                   resp_write_q, resp_write_d;
  logic [LW-1:0]          resp_latency_q, resp_latency_d;
  logic                   resp_timeout_q, resp_timeout_d;

  logic                   push;
  logic                   pop;
  logic                   done;
  logic [LW-1:0]          lat_inc;
  logic [EW-1:0]          head_entry;

  // Handshake and status; reqReady is held low while reset is asserted.
  assign reqReady = !reset && (count_q < CW'(DEPTH));
  assign busy     = (count_q != '0) || (state_q != ST_IDLE);

  assign respValid   = resp_valid_q;
  assign respData    = resp_data_q;
  assign respWrite   = resp_write_q;
  assign respLatency = resp_latency_q;
  assign respTimeout = resp_timeout_q;
  assign addrOut     = addr_out_q;
  assign dataOut     = data_out_q;
  assign enableOut   = enable_out_q;
  assign writeOut    = write_out_q;

  // Next-state computation for the FIFO pointers, the sequencer FSM and all registered outputs.
  always_comb begin
    push       = reqValid && reqReady;
    pop        = (state_q == ST_IDLE) && (count_q != '0);
    head_entry = mem_q[rd_ptr_q];
    // Writes also accept fetchComplete as their completion signal.
    done       = fetchComplete || (write_out_q && writeComplete);
    lat_inc    = lat_q + 1'b1;

    wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q + CW'(push) - CW'(pop);
    state_d        = state_q;
    lat_d          = lat_q;
    gap_d          = gap_q;
    addr_out_d     = addr_out_q;
    data_out_d     = data_out_q;
    enable_out_d   = enable_out_q;
    write_out_d    = write_out_q;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data_q;
    resp_write_d   = resp_write_q;
    resp_latency_d = resp_latency_q;
    resp_timeout_d = resp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          rd_ptr_d     = rd_ptr_q + 1'b1;
          write_out_d  = head_entry[EW-1];
          addr_out_d   = head_entry[EW-2:DATA_WIDTH];
          data_out_d   = head_entry[DATA_WIDTH-1:0];
          enable_out_d = 1'b1;
          lat_d        = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion takes priority over a timeout landing on the same edge.
        if (done || (lat_inc == LW'(TIMEOUT))) begin
          resp_valid_d   = 1'b1;
          resp_write_d   = write_out_q;
          resp_latency_d = lat_inc;
          resp_timeout_d = !done;
          resp_data_d    = (done && !write_out_q) ? dataIn : '0;
          enable_out_d   = 1'b0;
          write_out_d    = 1'b0;
          addr_out_d     = '0;
          data_out_d     = '0;
          gap_d          = '0;
          state_d        = ST_RELEASE;
        end else begin
          lat_d = lat_inc;
        end
      end
      ST_RELEASE: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {reqWrite, reqAddr, reqData};
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= ST_IDLE;
      lat_q          <= '0;
      gap_q          <= '0;
      addr_out_q     <= '0;
      data_out_q     <= '0;
      enable_out_q   <= 1'b0;
      write_out_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_write_q   <= 1'b0;
      resp_latency_q <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      lat_q          <= lat_d;
      gap_q          <= gap_d;
      addr_out_q     <= addr_out_d;
      data_out_q     <= data_out_d;
      enable_out_q   <= enable_out_d;
      write_out_q    <= write_out_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_write_q   <= resp_write_d;
      resp_latency_q <= resp_latency_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_request_sequencer
// Description : Directed bench for cache_request_sequencer with an L1 model
//               and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_request_sequencer;

  localparam int AW      = 11;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 63;
  localparam int GAP     = 1;
  localparam int LW      = $clog2(TIMEOUT + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [AW-1:0] reqAddr = '0;
  logic          reqWrite = 1'b0;
  logic [DW-1:0] reqData = '0;
  logic          respValid;
  logic [DW-1:0] respData;
  logic          respWrite;
  logic [LW-1:0] respLatency;
  logic          respTimeout;
  logic [AW-1:0] addrOut;
  logic [DW-1:0] dataOut;
  logic          enableOut;
  logic          writeOut;
  logic [DW-1:0] dataIn = '0;
  logic          fetchComplete = 1'b0;
  logic          writeComplete = 1'b0;
  logic          busy;

  cache_request_sequencer #(
    .ADDR_LENGTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)
  ) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
    .reqWrite(reqWrite), .reqData(reqData),
    .respValid(respValid), .respData(respData), .respWrite(respWrite),
    .respLatency(respLatency), .respTimeout(respTimeout),
    .addrOut(addrOut), .dataOut(dataOut), .enableOut(enableOut), .writeOut(writeOut),
    .dataIn(dataIn), .fetchComplete(fetchComplete), .writeComplete(writeComplete),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // One request plus how the L1 model should answer it (0 = never).
  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    int            fetch_at;
    int            write_at;
    logic [DW-1:0] rdata;
  } req_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          wr;
    int            lat;
    logic          to;
  } resp_t;

  req_t  issue_q[$];
  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the response a request should produce.
  function automatic resp_t predict(input req_t r);
    resp_t e;
    int    c;
    c = 0;
    if (r.fetch_at > 0) c = r.fetch_at;
    if (r.wr && r.write_at > 0 && (c == 0 || r.write_at < c)) c = r.write_at;
    e.wr = r.wr;
    if (c == 0 || c > TIMEOUT) begin
      e.data = '0;
      e.lat  = TIMEOUT;
      e.to   = 1'b1;
    end else begin
      e.data = r.wr ? '0 : r.rdata;
      e.lat  = c;
      e.to   = 1'b0;
    end
    return e;
  endfunction

  // L1 model and response monitor, both on the falling edge.
  req_t cur;
  int   ecnt = 0;
  always @(negedge clock) begin
    resp_t e;
    if (enableOut === 1'b1) begin
      if (ecnt == 0) begin
        chk("issue_pending", 64'(issue_q.size() != 0), 64'd1);
        if (issue_q.size() != 0) cur = issue_q.pop_front();
      end
      ecnt++;
      chk("issue_addr", 64'(addrOut), 64'(cur.addr));
      chk("issue_write", 64'(writeOut), 64'(cur.wr));
      chk("issue_data", 64'(dataOut), 64'(cur.wdata));
      fetchComplete = (cur.fetch_at != 0) && (ecnt == cur.fetch_at);
      writeComplete = (cur.write_at != 0) && (ecnt == cur.write_at);
      dataIn        = cur.rdata;
    end else begin
      ecnt          = 0;
      fetchComplete = 1'b0;
      writeComplete = 1'b0;
    end
    if (respValid === 1'b1) begin
      chk("resp_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("resp_data", 64'(respData), 64'(e.data));
        chk("resp_write", 64'(respWrite), 64'(e.wr));
        chk("resp_latency", 64'(respLatency), 64'(e.lat));
        chk("resp_timeout", 64'(respTimeout), 64'(e.to));
        chk("resp_enable_low", 64'(enableOut), 64'd0);
        chk("resp_addr_clear", 64'(addrOut), 64'd0);
        chk("resp_write_clear", 64'(writeOut), 64'd0);
      end
    end
  end

  task automatic push_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                          input int f_at, input int w_at, input logic [DW-1:0] rd,
                          input bit expect_resp);
    req_t r;
    int   waited;
    bit   ok;
    r.addr = a; r.wr = w; r.wdata = d; r.fetch_at = f_at; r.write_at = w_at; r.rdata = rd;
    waited = 0;
    ok = 1'b0;
    reqAddr = a; reqWrite = w; reqData = d; reqValid = 1'b1;
    while (!ok) begin
      @(negedge clock);
      if (reqReady === 1'b1) ok = 1'b1;
      else begin
        waited++;
        if (waited > 300) begin
          chk("push_accepted", 64'(reqReady), 64'd1);
          break;
        end
      end
    end
    if (ok) begin
      issue_q.push_back(r);
      if (expect_resp) exp_q.push_back(predict(r));
    end
    @(posedge clock);
    #1;
    reqValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy === 1'b0 && exp_q.size() == 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) chk("drain_busy", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Counts the enable-low cycles between the current request and the next.
  task automatic measure_gap(input string tag);
    int n;
    int low;
    n = 0;
    low = 0;
    while (enableOut !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    while (enableOut === 1'b1 && n < 400) begin @(negedge clock); n++; end
    while (enableOut !== 1'b1 && n < 600) begin
      low++;
      @(negedge clock);
      n++;
    end
    chk(tag, 64'(low), 64'(GAP + 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_enable", 64'(enableOut), 64'd0);
    chk("rst_resp_valid", 64'(respValid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(reqReady), 64'd0);
    chk("rst_addr", 64'(addrOut), 64'd0);
    chk("rst_latency", 64'(respLatency), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(reqReady), 64'd1);

    // Single read completing on the 12th enable cycle
    push_req(11'h000, 1'b0, 32'h0, 12, 0, 32'hDEADBEEF, 1'b1);
    wait_idle();

    // Write then read back-to-back, with the inter-request gap measured
    push_req(11'h004, 1'b1, 32'hFFFFFFFF, 0, 5, 32'h0, 1'b1);
    push_req(11'h004, 1'b0, 32'h0, 3, 0, 32'h600DF00D, 1'b1);
    measure_gap("gap_write_read");
    wait_idle();

    // Write that never completes, followed by a queued read
    push_req(11'h010, 1'b1, 32'h12345678, 0, 0, 32'h0, 1'b1);
    push_req(11'h014, 1'b0, 32'h0, 2, 0, 32'hCAFE0001, 1'b1);
    measure_gap("gap_after_timeout");
    wait_idle();

    // FIFO full: first request stalls, five get accepted before reqReady drops
    for (int i = 0; i < 6; i++) begin
      push_req(AW'(11'h100 + i), 1'(i % 2), DW'(32'hA000 + i), (i == 0) ? 20 : 2,
               (i % 2 == 1) ? 4 : 0, DW'(32'hB000 + i), 1'b1);
      if (i == 4) begin
        @(negedge clock);
        chk("fifo_full_ready", 64'(reqReady), 64'd0);
      end
    end
    wait_idle();

    // Completion on the same edge the timeout would fire
    push_req(11'h200, 1'b0, 32'h0, TIMEOUT, 0, 32'hA5A55A5A, 1'b1);
    wait_idle();

    // Reset while a request is waiting on the L1
    push_req(11'h123, 1'b0, 32'h0, 0, 0, 32'h55, 1'b0);
    repeat (4) @(posedge clock);
    #2;
    chk("pre_rst_enable", 64'(enableOut), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_enable", 64'(enableOut), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_resp_valid", 64'(respValid), 64'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("rel_rst_req_ready", 64'(reqReady), 64'd1);
    chk("rel_rst_busy", 64'(busy), 64'd0);
    repeat (20) @(posedge clock);
    #1;

    // Recovery: single-cycle completion after reset
    push_req(11'h7FF, 1'b0, 32'h0, 1, 0, 32'h13572468, 1'b1);
    wait_idle();
    chk("final_queue_empty", 64'(issue_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
